uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Transmit-direction buffer between the APB register interface and the UART transmitter.
//   APB writes bytes into a circular FIFO. A small FSM pops one byte at a time and hands it
//   to the UART TX with a one-cycle tx_start pulse, then waits for tx_done before the next.
//   Reports full/empty/level to the APB status register, plus a sticky overflow flag.
// PARAMETERS
//   DEPTH     8   FIFO entries; must be a power of 2
//   ADDR_W    3   log2(DEPTH); pointers are ADDR_W+1 bits wide (wrap bit in MSB)
//   TX_THRESH 2   low-water mark for irq_tx (used only with UART_TX_IRQ_EN)
// PORTS
//   clk      in   1         system clock, all logic on posedge
//   rst      in   1         asynchronous, active-low reset
//   wr_en    in   1         APB write strobe to THR, one cycle per byte
//   data_in  in   8         byte to enqueue
//   ovf_clr  in   1         clears ovf (APB write-1-to-clear)
//   tx_busy  in   1         UART TX is shifting a frame (level)
//   tx_done  in   1         UART TX finished a frame (one-cycle pulse)
//   tx_start out  1         one-cycle request for UART TX to send tx_data
//   tx_data  out  8         byte presented to UART TX; stable from tx_start until tx_done
//   f_tx     out  1         FIFO full
//   e_tx     out  1         FIFO empty
//   level    out  ADDR_W+1  current occupancy, 0..DEPTH
//   ovf      out  1         sticky: a write was dropped because the FIFO was full
//   irq_tx   out  1         low-water interrupt (tied 0 without UART_TX_IRQ_EN)
// BEHAVIOUR
//   Reset (rst=0, any time, async):
//     - w_ptr=r_ptr=0, state=IDLE.
//     - tx_start=0, tx_data=0, ovf=0, irq_tx=0; so e_tx=1, f_tx=0, level=0.
//     - mem contents are not cleared.
//     - Reset mid-frame abandons the in-flight byte; tx_done seen after reset is ignored.
//   Flags (combinational from the pointers):
//     - full = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) && (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0])
//     - empty = (w_ptr == r_ptr)
//     - level = w_ptr - r_ptr, modulo 2^(ADDR_W+1)
//   Write:
//     - wr_en && !f_tx: mem[w_ptr[ADDR_W-1:0]] <= data_in, w_ptr++.
//     - wr_en && f_tx: byte is dropped, pointers unchanged, ovf <= 1.
//     - f_tx is sampled before the edge, so a write while full is dropped even if a pop
//       occurs on the same edge.
//   ovf: ovf_clr clears it. If a set and a clear happen on the same edge, set wins.
//   FSM, registered, states IDLE / START / WAIT:
//     - IDLE: if !e_tx && !tx_busy, then tx_data <= mem[r_ptr], r_ptr++, tx_start <= 1,
//       and go to START. Otherwise stay in IDLE.
//     - START: tx_start <= 0, go to WAIT. tx_start is therefore high for exactly one cycle.
//     - WAIT: on tx_done go to IDLE. tx_done in IDLE or START is ignored.
//   Latency: a byte written into an empty FIFO with TX idle at edge N is popped at edge N+1,
//     so tx_start is high in cycle N+1..N+2. Back-to-back bytes have at least 1 idle cycle
//     between tx_done and the next tx_start.
//   Simultaneous push and pop: both occur and level is unchanged. Pointers wrap naturally
//     through the MSB.
// CONFIGURATION
//   UART_TX_IRQ_EN defined:
//     - irq_tx is registered: irq_tx <= (level <= TX_THRESH).
//     - It therefore asserts 1 cycle after the level crosses the threshold.
//   UART_TX_IRQ_EN undefined:
//     - irq_tx is tied 1'b0 and no threshold logic is synthesised.
//     - The port list is identical in both builds.
// STRUCTURE
//   Shared package uart_apb_pkg:
//     - UART_DATA_W=8.
//     - The TX FSM state encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2).
//     - Default DEPTH and ADDR_W.
//   One sub-module, uart_fifo_mem: DEPTH x 8 register array with a synchronous write port
//     and an asynchronous read port. Pointer, flag and FSM logic stay in the top level.
// TESTING
//   1. Reset, write 0xA5 with tx_busy=0. Expect: e_tx falls; the next cycle has tx_start=1
//      with tx_data=0xA5; tx_done returns the FSM to IDLE; e_tx=1.
//   2. Hold tx_busy=1 and write 8 bytes 0x00..0x07. Expect: f_tx=1, level=8.
//      Then write a 9th byte, 0xFF. Expect: dropped and ovf=1.
//      Then pulse ovf_clr. Expect: ovf=0.
//   3. Release tx_busy and ack each frame with tx_done. Expect: tx_data order 0x00..0x07,
//      exactly 8 tx_start pulses, and level counting down to 0.
//   4. Push and pop on the same edge at level=3. Expect: level stays 3.
//      Then run 20 pushes and pops. Expect: pointers wrap with no data corruption.
//   5. Assert rst in WAIT with 3 bytes queued. Expect: all outputs at reset values,
//      and a subsequent tx_done produces no tx_start.
//   6. With UART_TX_IRQ_EN and TX_THRESH=2, drain from 4 bytes. Expect: irq_tx rises
//      1 cycle after level reaches 2. Without the macro, irq_tx stays 0 throughout.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared UART/APB definitions: data width, default TX FIFO geometry, TX FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_apb_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_TX_DEPTH  = 8;
    localparam int UART_TX_ADDR_W = 3;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // TX handshake FSM; encodings are fixed so status readback stays stable
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array backing the UART TX FIFO.
// Latency: write lands on the next posedge; read is combinational from raddr_i.
// Backpressure: none; the caller gates we_i against FIFO full.
//
// Ports:
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write byte
//   raddr_i  read index
//   rdata_o  byte at raddr_i (asynchronous read)
module uart_fifo_mem
    import uart_apb_pkg::*;
#(
    parameter int DEPTH  = UART_TX_DEPTH,
    parameter int ADDR_W = UART_TX_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  uart_byte_t        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output uart_byte_t        rdata_o
);

    // No reset: contents are only meaningful between the pointers.
    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART TX buffer: APB bytes queue in a circular FIFO, an FSM hands them one at a time to the TX.
// Latency: byte written into an empty FIFO at edge N with TX idle raises tx_start_o after edge N+1.
// Backpressure: writes while full are dropped and set sticky ovf_o; pops wait for !tx_busy_i and tx_done_i.
//
// Ports:
//   clk_i       system clock (posedge)
//   rst_ni      asynchronous active-low reset
//   wr_en_i     APB THR write strobe, one cycle per byte
//   data_in_i   byte to enqueue
//   ovf_clr_i   write-1-to-clear for ovf_o
//   tx_busy_i   UART TX shifting a frame (level)
//   tx_done_i   UART TX finished a frame (pulse)
//   tx_start_o  one-cycle send request
//   tx_data_o   byte for UART TX, held from tx_start_o until tx_done_i
//   f_tx_o      FIFO full
//   e_tx_o      FIFO empty
//   level_o     occupancy 0..DEPTH
//   ovf_o       sticky overflow
//   irq_tx_o    low-water interrupt
//
// Build option: define UART_TX_IRQ_EN to enable the registered low-water interrupt
// (irq_tx_o = level_o <= TX_THRESH, one cycle late); otherwise irq_tx_o is tied low.
module uart_tx_fifo
    import uart_apb_pkg::*;
#(
    parameter int DEPTH     = UART_TX_DEPTH,
    parameter int ADDR_W    = UART_TX_ADDR_W,
    parameter int TX_THRESH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] data_in_i,
    input  logic                   ovf_clr_i,
    input  logic                   tx_busy_i,
    input  logic                   tx_done_i,
    output logic                   tx_start_o,
    output logic [UART_DATA_W-1:0] tx_data_o,
    output logic                   f_tx_o,
    output logic                   e_tx_o,
    output logic [ADDR_W:0]        level_o,
    output logic                   ovf_o,
    output logic                   irq_tx_o
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    // Elaboration-time sanity checks on the geometry
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must equal 2**ADDR_W");
    end
    if (TX_THRESH < 0 || TX_THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_tx_fifo: TX_THRESH out of range 0..DEPTH");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ADDR_W:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W:0] r_ptr_q, r_ptr_d;
    logic            ovf_q, ovf_d;
    tx_state_e       state_q, state_d;
    logic            tx_start_q, tx_start_d;
    uart_byte_t      tx_data_q, tx_data_d;

    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            push;
    uart_byte_t      rd_data;

    assign full  = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) &&
                   (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]);
    assign empty = (w_ptr_q == r_ptr_q);
    assign level = w_ptr_q - r_ptr_q;

    // Full is judged on pre-edge pointers, so a write at full is dropped even if a pop
    // frees a slot on the same edge.
    assign push = wr_en_i && !full;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (w_ptr_q[ADDR_W-1:0]),
        .wdata_i (data_in_i),
        .raddr_i (r_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    // Write side and sticky overflow; a set beats a simultaneous clear
    always_comb begin
        w_ptr_d = w_ptr_q;
        ovf_d   = ovf_q;
        if (push) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (wr_en_i && full) begin
            ovf_d = 1'b1;
        end
    end

    // TX handshake FSM: pop in IDLE, pulse in START, hold data until tx_done in WAIT
    always_comb begin
        state_d    = state_q;
        r_ptr_d    = r_ptr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            TX_IDLE: begin
                if (!empty && !tx_busy_i) begin
                    tx_data_d  = rd_data;
                    r_ptr_d    = r_ptr_q + PTR_ONE;
                    tx_start_d = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done_i) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_IRQ_EN
    localparam logic [ADDR_W:0] THRESH_L = (ADDR_W+1)'(TX_THRESH);

    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (level <= THRESH_L);
        end
    end

    assign irq_tx_o = irq_q;
`else
    assign irq_tx_o = 1'b0;
`endif

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign f_tx_o     = full;
    assign e_tx_o     = empty;
    assign level_o    = level;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single byte, fill/overflow, drain order,
// concurrent push/pop with wrap, reset mid-frame, and the low-water interrupt.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       ovf_clr;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_done_man;
    logic       ack_auto = 1'b0;
    logic       ack_arm  = 1'b0;
    logic       auto_ack = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       f_tx;
    logic       e_tx;
    logic [3:0] level;
    logic       ovf;
    logic       irq_tx;

    int         n_chk = 0;
    int         n_err = 0;
    int         n_pop = 0;
    logic [7:0] sb_q [$];

`ifdef UART_TX_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    assign tx_done = tx_done_man | ack_auto;

    uart_tx_fifo dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .data_in_i  (data_in),
        .ovf_clr_i  (ovf_clr),
        .tx_busy_i  (tx_busy),
        .tx_done_i  (tx_done),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .f_tx_o     (f_tx),
        .e_tx_o     (e_tx),
        .level_o    (level),
        .ovf_o      (ovf),
        .irq_tx_o   (irq_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one write strobe for one edge; returns at the following negedge
    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        data_in = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        for (int n = 0; n < budget && !tx_start; n++) tick();
        check_eq("tx_start_seen", 32'(tx_start), 1);
    endtask

    // Auto-responder: acks each frame one cycle after tx_start (FSM in WAIT), checks data order
    always @(negedge clk) begin
        ack_auto = ack_arm;
        ack_arm  = 1'b0;
        if (auto_ack && tx_start) begin
            n_pop++;
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check_eq("sb_data", tx_data, sb_q.pop_front());
            ack_arm = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; wr_en = 1'b0; data_in = 8'h00; ovf_clr = 1'b0;
        tx_busy = 1'b0; tx_done_man = 1'b0;

        // 1. reset values, then a single byte
        tick(); tick();
        check_eq("rst_e_tx", 32'(e_tx), 1);
        check_eq("rst_f_tx", 32'(f_tx), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_irq", 32'(irq_tx), 0);
        rst_n = 1'b1;
        tick();
        push(8'hA5);
        check_eq("t1_e_tx_fall", 32'(e_tx), 0);
        check_eq("t1_level", 32'(level), 1);
        check_eq("t1_no_start_yet", 32'(tx_start), 0);
        tick();
        check_eq("t1_start", 32'(tx_start), 1);
        check_eq("t1_data", tx_data, 8'hA5);
        check_eq("t1_e_tx", 32'(e_tx), 1);
        tick();
        check_eq("t1_start_one_cycle", 32'(tx_start), 0);
        check_eq("t1_data_held", tx_data, 8'hA5);
        tx_done_man = 1'b1; tick(); tx_done_man = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= int'(tx_start); end
        check_eq("t1_no_extra_start", seen, 0);
        check_eq("t1_empty_end", 32'(e_tx), 1);

        // 2. fill with TX busy, overflow, clear, set-wins-over-clear
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        check_eq("t2_full", 32'(f_tx), 1);
        check_eq("t2_level8", 32'(level), 8);
        check_eq("t2_not_empty", 32'(e_tx), 0);
        check_eq("t2_no_ovf_yet", 32'(ovf), 0);
        push(8'hFF);
        check_eq("t2_ovf_set", 32'(ovf), 1);
        check_eq("t2_level_after_drop", 32'(level), 8);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_eq("t2_ovf_clr", 32'(ovf), 0);
        ovf_clr = 1'b1; push(8'hEE); ovf_clr = 1'b0;
        check_eq("t2_ovf_set_wins", 32'(ovf), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_eq("t2_ovf_clr2", 32'(ovf), 0);

        // 3. release TX; a write on the pop edge is still dropped (full sampled pre-edge)
        tx_busy = 1'b0;
        push(8'hDD);
        check_eq("t3_ovf_pop_edge", 32'(ovf), 1);
        check_eq("t3_level7", 32'(level), 7);
        for (int i = 0; i < 8; i++) begin
            wait_start(6);
            check_eq("t3_data_order", tx_data, 32'(i));
            check_eq("t3_level_down", 32'(level), 32'(7 - i));
            tick();
            check_eq("t3_start_pulse", 32'(tx_start), 0);
            tx_done_man = 1'b1; tick(); tx_done_man = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); seen |= int'(tx_start); end
        check_eq("t3_only_8_starts", seen, 0);
        check_eq("t3_empty", 32'(e_tx), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // 4. push and pop on the same edge at level 3, then 20 paced pushes through the wrap
        tx_busy = 1'b1;
        push(8'h30); push(8'h31); push(8'h32);
        check_eq("t4_level3_pre", 32'(level), 3);
        sb_q = '{8'h30, 8'h31, 8'h32, 8'h33};
        n_pop = 0;
        auto_ack = 1'b1;
        tx_busy = 1'b0;
        push(8'h33);
        check_eq("t4_level3_same_edge", 32'(level), 3);
        check_eq("t4_pop_same_edge", 32'(tx_start), 1);
        for (int k = 0; k < 20; k++) begin
            sb_q.push_back(8'(8'h40 + k));
            push(8'(8'h40 + k));
            tick(); tick();
        end
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) tick();
        tick(); tick(); tick(); tick();
        check_eq("t4_sb_drained", sb_q.size(), 0);
        check_eq("t4_pop_count", n_pop, 24);
        check_eq("t4_empty", 32'(e_tx), 1);
        check_eq("t4_no_ovf", 32'(ovf), 0);
        auto_ack = 1'b0;

        // 5. reset while in WAIT with 3 bytes queued
        push(8'h50); push(8'h51); push(8'h52); push(8'h53);
        check_eq("t5_level3", 32'(level), 3);
        check_eq("t5_inflight_data", tx_data, 8'h50);
        check_eq("t5_start_low", 32'(tx_start), 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_level", 32'(level), 0);
        check_eq("t5_rst_e_tx", 32'(e_tx), 1);
        check_eq("t5_rst_f_tx", 32'(f_tx), 0);
        check_eq("t5_rst_tx_data", tx_data, 0);
        check_eq("t5_rst_tx_start", 32'(tx_start), 0);
        check_eq("t5_rst_ovf", 32'(ovf), 0);
        check_eq("t5_rst_irq", 32'(irq_tx), 0);
        tick();
        rst_n = 1'b1;
        tx_done_man = 1'b1; tick(); tx_done_man = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); seen |= int'(tx_start); end
        check_eq("t5_no_start_after_done", seen, 0);
        check_eq("t5_still_empty", 32'(e_tx), 1);

        // 6. low-water interrupt while draining from 4 bytes
        tx_busy = 1'b1;
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        check_eq("t6_level4", 32'(level), 4);
        check_eq("t6_irq_at4", 32'(irq_tx), 0);
        sb_q = '{8'h60, 8'h61, 8'h62, 8'h63};
        n_pop = 0;
        auto_ack = 1'b1;
        tx_busy = 1'b0;
        for (int n = 0; n < 40 && level != 4'd2; n++) tick();
        check_eq("t6_level_reaches2", 32'(level), 2);
        check_eq("t6_irq_same_cycle", 32'(irq_tx), 0);
        tick();
        check_eq("t6_irq_next_cycle", 32'(irq_tx), 32'(IRQ_EXP));
        for (int n = 0; n < 60 && sb_q.size() != 0; n++) tick();
        tick(); tick(); tick(); tick();
        check_eq("t6_pop_count", n_pop, 4);
        check_eq("t6_irq_drained", 32'(irq_tx), 32'(IRQ_EXP));
        auto_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
